// File: rtl/pipe_stage_skid.sv
// Two-entry pipeline stage with a skid register and registered in_ready.
// Optional downstream-stall counter enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
    parameter int PAYLOAD_W   = 197,
    parameter int CTRL_W      = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_payload,
    input  logic [CTRL_W-1:0]      in_ctrl,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int ENTRY_W = PAYLOAD_W + CTRL_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               in_ready_q;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;
    logic               in_acc;
    logic               out_acc;
    logic               load_main_in;
    logic               load_skid;
    logic               move_skid;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and in_ready comes from a flop only.
    assign in_acc  = in_valid & in_ready_q;
    assign out_acc = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    always_comb begin
        state_next   = state;
        load_main_in = 1'b0;
        load_skid    = 1'b0;
        move_skid    = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_acc) begin
                        load_main_in = 1'b1;
                        state_next   = ONE;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        load_main_in = 1'b1;
                    end else if (in_acc) begin
                        load_skid  = 1'b1;
                        state_next = TWO;
                    end else if (out_acc) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (out_acc) begin
                        move_skid  = 1'b1;
                        state_next = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid = (state == ONE) || (state == TWO);
        in_ready  = in_ready_q;
        out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : '0;
    end

    assign out_payload = main_q[ENTRY_W-1:CTRL_W];

    // Entries are not cleared on flush; state alone marks them dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= {in_payload, in_ctrl};
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= {in_payload, in_ctrl};
            end
        end
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_q;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (flush) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_ONE;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL provide parameter PAYLOAD_W, default 197, meaning width of the data payload (ALUResult 64 + WriteData 64 + Rd 5 + PCPlus4 64).
REQ-002 SHALL provide parameter CTRL_W, default 4, meaning width of the control bundle (RegWrite, ResultSrc[1:0], MemWrite).
REQ-003 SHALL provide parameter STALL_CNT_W, default 16, meaning width of the stall counter.
REQ-004 SHALL provide port clk, input, 1 bit: clock, rising-edge active.
REQ-005 SHALL provide port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL provide port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 SHALL provide port in_valid, input, 1 bit: upstream entry valid.
REQ-008 SHALL provide port in_ready, output, 1 bit: stage can accept an entry.
REQ-009 SHALL provide port in_payload, input, PAYLOAD_W bits: upstream data.
REQ-010 SHALL provide port in_ctrl, input, CTRL_W bits: upstream control.
REQ-011 SHALL provide port out_valid, output, 1 bit: downstream entry valid.
REQ-012 SHALL provide port out_ready, input, 1 bit: downstream accepts.
REQ-013 SHALL provide port out_payload, output, PAYLOAD_W bits: head-entry data.
REQ-014 SHALL provide port out_ctrl, output, CTRL_W bits: head-entry control.
REQ-015 SHALL provide port stall_cnt, output, STALL_CNT_W bits: downstream-stall cycle count.

Function
REQ-016 SHALL hold up to two entries (main register and skid register) under state machine EMPTY/ONE/TWO.
REQ-017 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in TWO, from a register only (no combinational path from out_ready).
REQ-018 SHALL drive out_valid = 1 in ONE and TWO, 0 in EMPTY; out_payload from the main register.
REQ-019 SHALL drive out_ctrl from the main register when out_valid = 1, else all zeros (bubble kills writes).
REQ-020 SHALL define in-accept = in_valid & in_ready and out-accept = out_valid & out_ready.
REQ-021 EMPTY: in-accept loads main, goes to ONE; otherwise stays EMPTY.
REQ-022 ONE: both accepts load main from input, stay ONE; in-accept only loads skid, goes to TWO; out-accept only goes to EMPTY.
REQ-023 TWO: out-accept moves skid into main, goes to ONE; otherwise holds.
REQ-024 SHALL pass data with 1-cycle latency from in-accept to out_valid when empty, and sustain one transfer per cycle with out_ready held high.
REQ-025 SHALL preserve order; no entry dropped or duplicated except on flush.
REQ-026 flush = 1 SHALL move the state to EMPTY next cycle, discard both entries and any same-cycle input, with priority over all transfers.
REQ-027 SHALL leave out_payload holding its last value when EMPTY; only out_ctrl is masked.

Reset
REQ-028 rst SHALL immediately force EMPTY, main and skid registers to zero, in_ready = 0 while rst is asserted, out_valid = 0, out_payload = 0, out_ctrl = 0, stall_cnt = 0.
REQ-029 SHALL raise in_ready on the first clk edge after rst deasserts; reset mid-transfer SHALL drop all held entries.

Configuration
REQ-030 With PIPE_STAGE_STALL_CNT_EN defined, stall_cnt SHALL increment on each cycle with out_valid = 1 and out_ready = 0, saturate at all ones, clear on flush.
REQ-031 Without PIPE_STAGE_STALL_CNT_EN, stall_cnt SHALL be tied to zero and no counter logic SHALL be built.

Verification
REQ-032 Reset release, in_valid=1, payload 0x5, ctrl 0xB, out_ready=1 -> out_valid=1, payload 0x5, ctrl 0xB after 1 cycle.
REQ-033 Stream 0x1..0x8 with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, in_ready constantly 1.
REQ-034 out_ready=0, send 0xA, 0xB -> TWO, in_ready=0; 0xC held off; out_ready=1 -> 0xA, 0xB, 0xC in order.
REQ-035 In TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, in_ready=1, no entry emitted.
REQ-036 With PIPE_STAGE_STALL_CNT_EN, STALL_CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; flush -> 0.
REQ-037 rst asserted in TWO -> out_valid=0, stall_cnt=0 immediately, without a clock edge.
